// File: rtl/sram_bank_req_seq_pkg.sv
// Shared types and constants for the SRAM bank request sequencer.
// Optional build macro used by the top level: SRAM_SEQ_PERF_CNT_EN.
package sram_bank_req_seq_pkg;

    localparam int BANK_LANES    = 4;
    localparam int LANE_WIDTH    = $clog2(BANK_LANES);
    localparam int SEQ_ROW_WIDTH = 7;
    localparam int SEQ_LEN_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WR    = 2'd1,
        RD    = 2'd2,
        DRAIN = 2'd3
    } seq_state_e;

    // Decoded burst request as presented on the request port.
    typedef struct packed {
        logic                     wr;
        logic                     mode;
        logic [SEQ_ROW_WIDTH-1:0] row;
        logic [LANE_WIDTH-1:0]    lane;
        logic [SEQ_LEN_WIDTH-1:0] len;
    } bank_req_t;

endpackage

// File: rtl/sram_bank_req_seq_if.sv
// Request, write-stream, response and bank-command signals of the sequencer.
// master = sequencer side, slave = cache data path plus bank wrapper side.
interface sram_bank_req_seq_if
    import sram_bank_req_seq_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 8
);
    logic                  req_vld;
    logic                  req_rdy;
    logic                  req_wr;
    logic                  req_mode;
    logic [ADDR_WIDTH-4:0] req_row;
    logic [LANE_WIDTH-1:0] req_lane;
    logic [LEN_WIDTH-1:0]  req_len;

    logic                  wdat_vld;
    logic                  wdat_rdy;
    logic [DATA_WIDTH-1:0] wdat;

    logic                  rsp_vld;
    logic                  rsp_rdy;
    logic [DATA_WIDTH-1:0] rsp_data;

    logic                  busy;

    logic [ADDR_WIDTH-1:0] addr;
    logic                  wr_cmd_vld;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  rd_cmd_vld;
    logic [DATA_WIDTH-1:0] rd_data;

    modport master (
        input  req_vld, req_wr, req_mode, req_row, req_lane, req_len,
        input  wdat_vld, wdat, rsp_rdy, rd_data,
        output req_rdy, wdat_rdy, rsp_vld, rsp_data, busy,
        output addr, wr_cmd_vld, wr_data, rd_cmd_vld
    );

    modport slave (
        output req_vld, req_wr, req_mode, req_row, req_lane, req_len,
        output wdat_vld, wdat, rsp_rdy, rd_data,
        input  req_rdy, wdat_rdy, rsp_vld, rsp_data, busy,
        input  addr, wr_cmd_vld, wr_data, rd_cmd_vld
    );

endinterface

// File: rtl/sram_seq_rsp_fifo.sv
// Read-response FIFO for the bank sequencer; output is read from registered
// storage and forced to zero while empty.
module sram_seq_rsp_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int RSP_DEPTH  = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push_i,
    input  logic [DATA_WIDTH-1:0]     push_data_i,
    input  logic                      pop_i,
    output logic [DATA_WIDTH-1:0]     pop_data_o,
    output logic                      vld_o,
    output logic [$clog2(RSP_DEPTH):0] count_o
);
    localparam int PTR_WIDTH = $clog2(RSP_DEPTH);
    localparam int CNT_WIDTH = PTR_WIDTH + 1;

    logic [DATA_WIDTH-1:0] mem_q [RSP_DEPTH];
    logic [PTR_WIDTH-1:0]  wr_ptr_q;
    logic [PTR_WIDTH-1:0]  rd_ptr_q;
    logic [CNT_WIDTH-1:0]  count_q;
    logic [CNT_WIDTH-1:0]  count_d;
    logic                  do_pop;
    logic                  full;

    assign full    = (count_q == CNT_WIDTH'(RSP_DEPTH));
    assign vld_o   = (count_q != '0);
    assign do_pop  = pop_i && vld_o;
    assign count_d = count_q + CNT_WIDTH'(push_i) - CNT_WIDTH'(do_pop);
    assign count_o = count_q;

    assign pop_data_o = vld_o ? mem_q[rd_ptr_q] : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                wr_ptr_q <= wr_ptr_q + PTR_WIDTH'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_WIDTH'(1);
            end
            count_q <= count_d;
        end
    end

    // Storage needs no reset: entries are only visible once counted in.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    sim_assert_no_overflow : assert property (
        @(posedge clk) disable iff (rst) !(push_i && full && !pop_i)
    );

endmodule

// File: rtl/sram_bank_req_seq.sv
// Burst sequencer driving one SRAM bank wrapper: one bank command per cycle.
// Optional perf counters are enabled by defining SRAM_SEQ_PERF_CNT_EN.
module sram_bank_req_seq
    import sram_bank_req_seq_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 8,
    parameter int RSP_DEPTH  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    sram_bank_req_seq_if.master  bus
`ifdef SRAM_SEQ_PERF_CNT_EN
    ,
    output logic [31:0]          perf_cmd_cnt,
    output logic [31:0]          perf_stall_cnt
`endif
);
    localparam int ROW_WIDTH = ADDR_WIDTH - 3;
    localparam int POS_WIDTH = ROW_WIDTH + LANE_WIDTH;
    localparam int CNT_WIDTH = $clog2(RSP_DEPTH) + 1;

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_WR    = WR;
    localparam logic [1:0] ST_RD    = RD;
    localparam logic [1:0] ST_DRAIN = DRAIN;

    logic [1:0]            state_q, state_d;
    logic                  mode_q, mode_d;
    logic [POS_WIDTH-1:0]  pos_q, pos_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [LEN_WIDTH-1:0]  beat_q, beat_d;
    logic [ADDR_WIDTH-1:0] last_addr_q, last_addr_d;
    logic                  cap_q, cap_d;

    logic [CNT_WIDTH-1:0]  fifo_count;
    logic                  credit;
    logic                  rd_issue;
    logic                  wr_fire;
    logic                  last_beat;
    logic [ADDR_WIDTH-1:0] cur_addr;
    bank_req_t             req_in;

    assign req_in = '{wr: bus.req_wr, mode: bus.req_mode, row: bus.req_row,
                      lane: bus.req_lane, len: bus.req_len};

    // pos_q is {row, lane} of the next beat, so one increment steps lane and carries into row.
    assign cur_addr  = {pos_q, mode_q};
    assign credit    = (fifo_count + CNT_WIDTH'(cap_q)) < CNT_WIDTH'(RSP_DEPTH);
    assign rd_issue  = (state_q == ST_RD) && credit;
    assign wr_fire   = (state_q == ST_WR) && bus.wdat_vld;
    assign last_beat = (beat_q == len_q);

    assign bus.req_rdy    = (state_q == ST_IDLE) && !rst;
    assign bus.wdat_rdy   = (state_q == ST_WR);
    assign bus.wr_cmd_vld = wr_fire;
    assign bus.wr_data    = (state_q == ST_WR) ? bus.wdat : '0;
    assign bus.rd_cmd_vld = rd_issue | cap_q;
    assign bus.addr       = ((state_q == ST_WR) || rd_issue) ? cur_addr : last_addr_q;
    assign bus.busy       = (state_q != ST_IDLE) || (fifo_count != '0);

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        pos_d       = pos_q;
        len_d       = len_q;
        beat_d      = beat_q;
        last_addr_d = last_addr_q;
        cap_d       = rd_issue;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_vld) begin
                    mode_d  = req_in.mode;
                    pos_d   = {req_in.row, req_in.lane};
                    len_d   = req_in.len;
                    beat_d  = '0;
                    state_d = req_in.wr ? ST_WR : ST_RD;
                end
            end
            ST_WR: begin
                if (wr_fire) begin
                    pos_d       = pos_q + POS_WIDTH'(1);
                    beat_d      = beat_q + LEN_WIDTH'(1);
                    last_addr_d = cur_addr;
                    if (last_beat) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_RD: begin
                if (rd_issue) begin
                    pos_d       = pos_q + POS_WIDTH'(1);
                    beat_d      = beat_q + LEN_WIDTH'(1);
                    last_addr_d = cur_addr;
                    if (last_beat) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            mode_q      <= 1'b0;
            pos_q       <= '0;
            len_q       <= '0;
            beat_q      <= '0;
            last_addr_q <= '0;
            cap_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            pos_q       <= pos_d;
            len_q       <= len_d;
            beat_q      <= beat_d;
            last_addr_q <= last_addr_d;
            cap_q       <= cap_d;
        end
    end

    // The bank only drives rd_data while rd_cmd_vld is high, which cap_q guarantees.
    sram_seq_rsp_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .RSP_DEPTH  (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (cap_q),
        .push_data_i (bus.rd_data),
        .pop_i       (bus.rsp_rdy),
        .pop_data_o  (bus.rsp_data),
        .vld_o       (bus.rsp_vld),
        .count_o     (fifo_count)
    );

`ifdef SRAM_SEQ_PERF_CNT_EN
    logic [31:0] perf_cmd_q;
    logic [31:0] perf_stall_q;
    logic        stall_evt;

    assign stall_evt = ((state_q == ST_WR) && !bus.wdat_vld) ||
                       ((state_q == ST_RD) && !credit);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_cmd_q   <= '0;
            perf_stall_q <= '0;
        end else begin
            if ((rd_issue || wr_fire) && (perf_cmd_q != '1)) begin
                perf_cmd_q <= perf_cmd_q + 32'd1;
            end
            if (stall_evt && (perf_stall_q != '1)) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
        end
    end

    assign perf_cmd_cnt   = perf_cmd_q;
    assign perf_stall_cnt = perf_stall_q;
`endif

endmodule

// File: tb/tb_sram_bank_req_seq.sv
// Directed bench for sram_bank_req_seq: table-driven write bursts plus
// hand-written read, back-pressure and reset sequences against a bank model.
`timescale 1ns/1ps
module tb_sram_bank_req_seq;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam int LW = 8;
    localparam int RD = 4;

    typedef struct {
        logic [6:0] row;
        logic [1:0] lane;
        logic [7:0] len;
        int         first;
        int         count;
    } reqVec_t;

    typedef struct {
        logic        vld;
        logic [31:0] data;
        logic        expCmd;
        logic [9:0]  expAddr;
    } wrVec_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   fails  = 0;

    always #5 clk = ~clk;

    sram_bank_req_seq_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) bus ();

`ifdef SRAM_SEQ_PERF_CNT_EN
    logic [31:0] perfCmd;
    logic [31:0] perfStall;
`endif

    sram_bank_req_seq #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .LEN_WIDTH  (LW),
        .RSP_DEPTH  (RD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef SRAM_SEQ_PERF_CNT_EN
        ,
        .perf_cmd_cnt   (perfCmd),
        .perf_stall_cnt (perfStall)
`endif
    );

    // Bank model: one-cycle read latency, output only meaningful while rd_cmd_vld is high.
    logic [31:0] bankMem [1024];
    logic [31:0] bankRdReg = 32'h0;

    always @(posedge clk) begin
        if (bus.wr_cmd_vld) bankMem[bus.addr] <= bus.wr_data;
        if (bus.rd_cmd_vld) bankRdReg <= bankMem[bus.addr];
    end

    assign bus.rd_data = bus.rd_cmd_vld ? bankRdReg : 32'hDEAD_BEEF;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Presents one burst request for a single accepting cycle; returns just after that edge.
    task automatic applyStimulus(input logic wr, input logic mode, input logic [6:0] row,
                                 input logic [1:0] lane, input logic [7:0] len);
        bus.req_vld  = 1'b1;
        bus.req_wr   = wr;
        bus.req_mode = mode;
        bus.req_row  = row;
        bus.req_lane = lane;
        bus.req_len  = len;
        @(negedge clk);
        checkOutput("req_rdy before accept", bus.req_rdy, 1);
        @(posedge clk);
        #1;
        bus.req_vld = 1'b0;
    endtask

    reqVec_t     reqTab [3];
    wrVec_t      wrTab  [11];
    logic [6:0]  rbRd;
    logic [6:0]  rbVld;
    logic [9:0]  rbAddr [5];
    logic [7:0]  blRd;
    logic [7:0]  blVld;
    logic [9:0]  blAddr [5];
    int          dataIdx;
    int          got;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reqTab[0] = '{7'd5,   2'd2, 8'd3, 0, 4};
        reqTab[1] = '{7'd10,  2'd1, 8'd2, 4, 5};
        reqTab[2] = '{7'd127, 2'd3, 8'd1, 9, 2};

        wrTab[0]  = '{1'b1, 32'hA0, 1'b1, 10'd44};
        wrTab[1]  = '{1'b1, 32'hA1, 1'b1, 10'd46};
        wrTab[2]  = '{1'b1, 32'hA2, 1'b1, 10'd48};
        wrTab[3]  = '{1'b1, 32'hA3, 1'b1, 10'd50};
        wrTab[4]  = '{1'b1, 32'hB0, 1'b1, 10'd82};
        wrTab[5]  = '{1'b0, 32'hB1, 1'b0, 10'd84};
        wrTab[6]  = '{1'b1, 32'hB2, 1'b1, 10'd84};
        wrTab[7]  = '{1'b0, 32'hB3, 1'b0, 10'd86};
        wrTab[8]  = '{1'b1, 32'hB4, 1'b1, 10'd86};
        wrTab[9]  = '{1'b1, 32'hC0, 1'b1, 10'd1022};
        wrTab[10] = '{1'b1, 32'hC1, 1'b1, 10'd0};

        rbRd   = 7'b0011111;
        rbVld  = 7'b0111100;
        rbAddr = '{10'd44, 10'd46, 10'd48, 10'd50, 10'd50};
        blRd   = 8'b00011111;
        blVld  = 8'b11111100;
        blAddr = '{10'd1, 10'd3, 10'd5, 10'd7, 10'd7};

        for (int i = 0; i < 1024; i++) bankMem[i] = 32'h1000_0000 + 32'(i);

        rst          = 1'b1;
        bus.req_vld  = 1'b0;
        bus.req_wr   = 1'b0;
        bus.req_mode = 1'b0;
        bus.req_row  = '0;
        bus.req_lane = '0;
        bus.req_len  = '0;
        bus.wdat_vld = 1'b0;
        bus.wdat     = '0;
        bus.rsp_rdy  = 1'b0;

        @(negedge clk);
        checkOutput("reset req_rdy", bus.req_rdy, 0);
        checkOutput("reset busy", bus.busy, 0);
        checkOutput("reset addr", bus.addr, 0);
        checkOutput("reset rsp_vld", bus.rsp_vld, 0);
        checkOutput("reset cmds", {bus.wr_cmd_vld, bus.rd_cmd_vld}, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("post-reset req_rdy", bus.req_rdy, 1);
        @(posedge clk);
        #1;

        // Write bursts: plain word burst, toggling wdat_vld, and row wrap.
        for (int r = 0; r < 3; r++) begin
            applyStimulus(1'b1, 1'b0, reqTab[r].row, reqTab[r].lane, reqTab[r].len);
            for (int k = reqTab[r].first; k < reqTab[r].first + reqTab[r].count; k++) begin
                bus.wdat_vld = wrTab[k].vld;
                bus.wdat     = wrTab[k].data;
                @(negedge clk);
                checkOutput($sformatf("wr[%0d] wr_cmd_vld", k), bus.wr_cmd_vld, wrTab[k].expCmd);
                checkOutput($sformatf("wr[%0d] addr", k), bus.addr, wrTab[k].expAddr);
                checkOutput($sformatf("wr[%0d] wr_data", k), bus.wr_data, wrTab[k].data);
                checkOutput($sformatf("wr[%0d] wdat_rdy", k), bus.wdat_rdy, 1);
                checkOutput($sformatf("wr[%0d] rd_cmd_vld", k), bus.rd_cmd_vld, 0);
                @(posedge clk);
                #1;
            end
            bus.wdat_vld = 1'b0;
            @(negedge clk);
            checkOutput($sformatf("wr burst %0d back to idle", r), bus.req_rdy, 1);
            checkOutput($sformatf("wr burst %0d wdat_rdy low", r), bus.wdat_rdy, 0);
            @(posedge clk);
            #1;
        end

        // Word read-back with rsp_rdy high: A0..A3 back to back, rsp 2 cycles after first issue.
        bus.rsp_rdy = 1'b1;
        applyStimulus(1'b0, 1'b0, 7'd5, 2'd2, 8'd3);
        dataIdx = 0;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            checkOutput($sformatf("rb c%0d rd_cmd_vld", c), bus.rd_cmd_vld, rbRd[c]);
            checkOutput($sformatf("rb c%0d rsp_vld", c), bus.rsp_vld, rbVld[c]);
            checkOutput($sformatf("rb c%0d cmd exclusive", c), bus.wr_cmd_vld & bus.rd_cmd_vld, 0);
            if (c < 5) checkOutput($sformatf("rb c%0d addr", c), bus.addr, rbAddr[c]);
            if (rbVld[c]) begin
                checkOutput($sformatf("rb beat %0d rsp_data", dataIdx), bus.rsp_data, 32'hA0 + 32'(dataIdx));
                dataIdx++;
            end
            @(posedge clk);
            #1;
        end
        checkOutput("rb busy after", bus.busy, 0);

        // Byte-lane read with rsp_rdy low: 4 issues, one repeat read, then stall.
        bus.rsp_rdy = 1'b0;
        applyStimulus(1'b0, 1'b1, 7'd0, 2'd0, 8'd7);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            checkOutput($sformatf("bl c%0d rd_cmd_vld", c), bus.rd_cmd_vld, blRd[c]);
            checkOutput($sformatf("bl c%0d rsp_vld", c), bus.rsp_vld, blVld[c]);
            if (c < 5) checkOutput($sformatf("bl c%0d addr", c), bus.addr, blAddr[c]);
            if (blVld[c]) checkOutput($sformatf("bl c%0d head data", c), bus.rsp_data, 32'h1000_0001);
            @(posedge clk);
            #1;
        end
        bus.rsp_rdy = 1'b1;
        got = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (bus.rsp_vld) begin
                if (got < 8) begin
                    checkOutput($sformatf("bl beat %0d rsp_data", got), bus.rsp_data,
                                32'h1000_0001 + 32'(2 * got));
                end else begin
                    checks++;
                    fails++;
                    $display("[TB] FAIL bl extra beat: got %0h, expected no response", bus.rsp_data);
                end
                got++;
            end
            @(posedge clk);
            #1;
        end
        checkOutput("bl beat count", 32'(got), 8);
        checkOutput("bl busy after", bus.busy, 0);

        // Reset in the middle of a read burst with two beats buffered.
        bus.rsp_rdy = 1'b0;
        applyStimulus(1'b0, 1'b0, 7'd5, 2'd2, 8'd7);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (c < 3) begin
                @(posedge clk);
                #1;
            end
        end
        checkOutput("rst pre rsp_vld", bus.rsp_vld, 1);
        checkOutput("rst pre busy", bus.busy, 1);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("rst req_rdy", bus.req_rdy, 0);
        checkOutput("rst rsp_vld", bus.rsp_vld, 0);
        checkOutput("rst rsp_data", bus.rsp_data, 0);
        checkOutput("rst rd_cmd_vld", bus.rd_cmd_vld, 0);
        checkOutput("rst addr", bus.addr, 0);
        checkOutput("rst busy", bus.busy, 0);
        checkOutput("rst wdat_rdy", bus.wdat_rdy, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.rsp_rdy = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checkOutput($sformatf("post-rst c%0d rsp_vld", c), bus.rsp_vld, 0);
            checkOutput($sformatf("post-rst c%0d req_rdy", c), bus.req_rdy, 1);
            checkOutput($sformatf("post-rst c%0d rd_cmd_vld", c), bus.rd_cmd_vld, 0);
            @(posedge clk);
            #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
